// File: rtl/uart_tx_feeder.sv
// uart_tx_feeder
//   Byte FIFO and sequencer that sits directly upstream of the UART transmitter.
//   Bytes are queued at any rate. They are then presented one at a time on
//   tx_data, each announced by a one-cycle tx_start pulse. The block waits for
//   the transmitter's tx_ready pulse before moving on. An optional idle gap
//   follows each completed byte, and a watchdog abandons a byte when the
//   transmitter never answers.
// Ports
//   clk        : clock
//   reset_n    : asynchronous active-low reset
//   flush      : synchronous clear of FIFO and sequencer
//   wr_en      : write strobe, one byte per cycle
//   wr_data    : byte to queue
//   full       : FIFO holds 2**ADDR_W bytes
//   empty      : FIFO holds no bytes
//   level      : bytes queued, excluding the byte in flight
//   overflow   : one-cycle pulse, a write arrived while full and was dropped
//   tx_data    : byte to the transmitter, stable from LOAD until WAIT is left
//   tx_start   : one-cycle transmission request
//   tx_ready   : one-cycle completion pulse from the transmitter
//   busy       : sequencer not idle
//   tx_timeout : one-cycle pulse, WAIT expired without tx_ready
module uart_tx_feeder #(
   parameter int ADDR_W      = 4,
   parameter int GAP_CYCLES  = 0,
   parameter int TIMEOUT_CYC = 65535
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              flush,
   input  logic              wr_en,
   input  logic [7:0]        wr_data,
   output logic              full,
   output logic              empty,
   output logic [ADDR_W:0]   level,
   output logic              overflow,
   output logic [7:0]        tx_data,
   output logic              tx_start,
   input  logic              tx_ready,
   output logic              busy,
   output logic              tx_timeout
);

   localparam int                DEPTH     = 1 << ADDR_W;
   localparam logic [ADDR_W:0]   LVL_DEPTH = (ADDR_W + 1)'(DEPTH);
   localparam logic [ADDR_W:0]   LVL_ZERO  = (ADDR_W + 1)'(0);
   localparam logic [ADDR_W:0]   LVL_ONE   = (ADDR_W + 1)'(1);
   localparam logic [ADDR_W-1:0] PTR_ZERO  = ADDR_W'(0);
   localparam logic [ADDR_W-1:0] PTR_ONE   = ADDR_W'(1);
   localparam logic [15:0]       GAP_LAST  = 16'(GAP_CYCLES - 1);
   localparam logic [15:0]       TO_LAST   = 16'(TIMEOUT_CYC - 1);
   localparam bit                GAP_EN    = (GAP_CYCLES > 0);
   localparam bit                TO_EN     = (TIMEOUT_CYC > 0);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_LOAD  = 3'd1,
      S_START = 3'd2,
      S_WAIT  = 3'd3,
      S_GAP   = 3'd4
   } state_t;

   state_t            state_r;
   logic [7:0]        mem_r [DEPTH];
   logic [ADDR_W-1:0] wr_ptr_r;
   logic [ADDR_W-1:0] rd_ptr_r;
   logic [ADDR_W:0]   level_r;
   logic [15:0]       cnt_r;
   logic              full_r;
   logic              empty_r;
   logic              overflow_r;
   logic [7:0]        tx_data_r;
   logic              tx_start_r;
   logic              busy_r;
   logic              tx_timeout_r;
   logic              wr_acc_s;
   logic              rd_s;
   logic [ADDR_W:0]   level_nxt_s;

   // Accept/read decisions and the next FIFO occupancy. The full test uses the
   // registered flag, so a read in the same cycle never makes room for a write.
   always_comb begin
      wr_acc_s = wr_en & ~full_r & ~flush;
      rd_s     = (state_r == S_LOAD) & ~flush;
      if (wr_acc_s & ~rd_s) begin
         level_nxt_s = level_r + LVL_ONE;
      end else if (rd_s & ~wr_acc_s) begin
         level_nxt_s = level_r - LVL_ONE;
      end else begin
         level_nxt_s = level_r;
      end
   end

   // Byte storage, written only on accepted writes.
   always_ff @(posedge clk) begin
      if (wr_acc_s) begin
         mem_r[wr_ptr_r] <= wr_data;
      end else begin
         mem_r[wr_ptr_r] <= mem_r[wr_ptr_r];
      end
   end

   // FIFO pointers, occupancy flags and the overflow pulse.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr_r   <= PTR_ZERO;
         rd_ptr_r   <= PTR_ZERO;
         level_r    <= LVL_ZERO;
         full_r     <= 1'b0;
         empty_r    <= 1'b1;
         overflow_r <= 1'b0;
      end else if (flush) begin
         // A write in the flush cycle is silently discarded.
         wr_ptr_r   <= PTR_ZERO;
         rd_ptr_r   <= PTR_ZERO;
         level_r    <= LVL_ZERO;
         full_r     <= 1'b0;
         empty_r    <= 1'b1;
         overflow_r <= 1'b0;
      end else begin
         if (wr_acc_s) begin
            wr_ptr_r <= wr_ptr_r + PTR_ONE;
         end else begin
            wr_ptr_r <= wr_ptr_r;
         end
         if (rd_s) begin
            rd_ptr_r <= rd_ptr_r + PTR_ONE;
         end else begin
            rd_ptr_r <= rd_ptr_r;
         end
         level_r    <= level_nxt_s;
         full_r     <= (level_nxt_s == LVL_DEPTH);
         empty_r    <= (level_nxt_s == LVL_ZERO);
         overflow_r <= wr_en & full_r;
      end
   end

   // Sequencer: IDLE -> LOAD -> START -> WAIT -> (GAP) -> IDLE, all outputs registered.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_r      <= S_IDLE;
         cnt_r        <= 16'd0;
         tx_data_r    <= 8'h00;
         tx_start_r   <= 1'b0;
         busy_r       <= 1'b0;
         tx_timeout_r <= 1'b0;
      end else if (flush) begin
         // tx_data is intentionally kept; a byte already on the line finishes there.
         state_r      <= S_IDLE;
         cnt_r        <= 16'd0;
         tx_start_r   <= 1'b0;
         busy_r       <= 1'b0;
         tx_timeout_r <= 1'b0;
      end else begin
         tx_start_r   <= 1'b0;
         tx_timeout_r <= 1'b0;
         case (state_r)
            S_IDLE: begin
               // Look at the incoming write too, so a byte written into an
               // empty FIFO reaches LOAD on the very next cycle.
               if (~empty_r | wr_acc_s) begin
                  state_r <= S_LOAD;
                  busy_r  <= 1'b1;
               end else begin
                  busy_r  <= 1'b0;
               end
            end
            S_LOAD: begin
               tx_data_r  <= mem_r[rd_ptr_r];
               tx_start_r <= 1'b1;
               state_r    <= S_START;
            end
            S_START: begin
               cnt_r   <= 16'd0;
               state_r <= S_WAIT;
            end
            S_WAIT: begin
               if (tx_ready) begin
                  cnt_r <= 16'd0;
                  if (GAP_EN) begin
                     state_r <= S_GAP;
                  end else begin
                     state_r <= S_IDLE;
                     busy_r  <= 1'b0;
                  end
               end else if (TO_EN && (cnt_r == TO_LAST)) begin
                  tx_timeout_r <= 1'b1;
                  state_r      <= S_IDLE;
                  busy_r       <= 1'b0;
               end else begin
                  cnt_r <= cnt_r + 16'd1;
               end
            end
            S_GAP: begin
               if (cnt_r == GAP_LAST) begin
                  state_r <= S_IDLE;
                  busy_r  <= 1'b0;
               end else begin
                  cnt_r <= cnt_r + 16'd1;
               end
            end
            default: begin
               state_r <= S_IDLE;
               busy_r  <= 1'b0;
            end
         endcase
      end
   end

   assign full       = full_r;
   assign empty      = empty_r;
   assign level      = level_r;
   assign overflow   = overflow_r;
   assign tx_data    = tx_data_r;
   assign tx_start   = tx_start_r;
   assign busy       = busy_r;
   assign tx_timeout = tx_timeout_r;

endmodule
